// File: rtl/spi_burst_shifter_if.sv
// Word-stream and SPI pin bundle for spi_burst_shifter; master = sequencer side, slave = shift engine.
interface spi_burst_shifter_if #(
    parameter int DW    = 8,
    parameter int DIV_W = 4
);
    logic             i_valid;
    logic             o_ready;
    logic [DW-1:0]    i_data;
    logic             i_dc;
    logic             i_last;
    logic [DIV_W-1:0] i_div;
    logic             i_miso;
    logic             o_sck;
    logic             o_mosi;
    logic             o_cs;
    logic             o_dc;
    logic [DW-1:0]    o_rx_data;
    logic             o_rx_valid;
    logic             o_busy;

    modport master (
        output i_valid, i_data, i_dc, i_last, i_div, i_miso,
        input  o_ready, o_sck, o_mosi, o_cs, o_dc, o_rx_data, o_rx_valid, o_busy
    );

    modport slave (
        input  i_valid, i_data, i_dc, i_last, i_div, i_miso,
        output o_ready, o_sck, o_mosi, o_cs, o_dc, o_rx_data, o_rx_valid, o_busy
    );
endinterface

// File: rtl/spi_burst_shifter.sv
// Mode-0 SPI master streaming DW-bit words in CS-contiguous bursts; pins update 1 clk after accept, first SCK rise i_div+1 clk later.
// o_ready is high in IDLE/GAP and only on the final falling edge of a non-last word, so back-to-back words shift with no SCK gap.
module spi_burst_shifter #(
    parameter int DW        = 8,
    parameter int DIV_W     = 4,
    parameter int LSB_FIRST = 0,
    parameter int CS_HOLD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_burst_shifter_if.slave  spi
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, HOLD} state_t;

    localparam int BW = $clog2(DW);
    localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] half_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [DW-1:0]    tx_sr, tx_nxt;
    logic [DW-1:0]    rx_sr, rx_nxt;
    logic [DW-1:0]    rx_dat_q;
    logic             rx_vld_q;
    logic             last_q, sck_q, mosi_q, cs_q, dc_q;
    logic             tick, word_end, hold_done, ready, accept;

    function automatic logic first_bit(input logic [DW-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DW-1];
    endfunction

    always_comb begin
        if (LSB_FIRST != 0) begin
            tx_nxt = tx_sr >> 1;
            rx_nxt = {spi.i_miso, rx_sr[DW-1:1]};
        end else begin
            tx_nxt = tx_sr << 1;
            rx_nxt = {rx_sr[DW-2:0], spi.i_miso};
        end
    end

    always_comb begin
        tick      = (half_cnt == div_q);
        word_end  = (state == SHIFT) && tick && sck_q && (bit_cnt == LAST_BIT);
        hold_done = (state == HOLD) && (hold_cnt == HOLD_LAST);
        ready     = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (spi.i_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                ready = word_end && !last_q;
                if (word_end) begin
                    if (last_q)           state_nxt = HOLD;
                    else if (spi.i_valid) state_nxt = SHIFT;
                    else                  state_nxt = GAP;
                end
            end
            GAP: begin
                ready = 1'b1;
                if (spi.i_valid) state_nxt = SHIFT;
            end
            HOLD: begin
                if (hold_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = spi.i_valid && ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_dat_q <= '0;
            rx_vld_q <= 1'b0;
            last_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b1;
            cs_q     <= 1'b1;
            dc_q     <= 1'b1;
        end else begin
            rx_vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    hold_cnt <= '0;
                end
                SHIFT: begin
                    if (tick) begin
                        half_cnt <= '0;
                        sck_q    <= ~sck_q;
                        if (!sck_q) begin
                            rx_sr <= rx_nxt;
                        end else if (bit_cnt == LAST_BIT) begin
                            // mosi keeps the last bit through GAP/HOLD
                            bit_cnt  <= '0;
                            hold_cnt <= '0;
                            rx_dat_q <= rx_sr;
                            rx_vld_q <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sr   <= tx_nxt;
                            mosi_q  <= first_bit(tx_nxt);
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        cs_q   <= 1'b1;
                        mosi_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            // a new word overrides the end-of-word updates; divider only latches at burst start
            if (accept) begin
                tx_sr    <= spi.i_data;
                mosi_q   <= first_bit(spi.i_data);
                dc_q     <= spi.i_dc;
                last_q   <= spi.i_last;
                cs_q     <= 1'b0;
                half_cnt <= '0;
                bit_cnt  <= '0;
                if (state == IDLE) div_q <= spi.i_div;
            end
        end
    end

    assign spi.o_ready    = ready;
    assign spi.o_sck      = sck_q;
    assign spi.o_mosi     = mosi_q;
    assign spi.o_cs       = cs_q;
    assign spi.o_dc       = dc_q;
    assign spi.o_rx_data  = rx_dat_q;
    assign spi.o_rx_valid = rx_vld_q;
    assign spi.o_busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_burst_shifter.sv
// Directed bench: single-word vector table, then burst, stall, divider-latch, reset and LSB-first sequences.
module tb_spi_burst_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_burst_shifter_if #(.DW(8), .DIV_W(4)) if0 ();
    spi_burst_shifter_if #(.DW(8), .DIV_W(4)) if1 ();

    spi_burst_shifter #(.DW(8), .DIV_W(4), .LSB_FIRST(0), .CS_HOLD(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .spi (if0)
    );

    spi_burst_shifter #(.DW(8), .DIV_W(4), .LSB_FIRST(1), .CS_HOLD(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .spi (if1)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic [3:0] div;
        logic [7:0] miso;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_dc;
        int         exp_cs;
        int         exp_first;
        int         exp_last;
        int         exp_hi;
    } vec_t;

    vec_t vecs [4];

    // dut0 monitor + mode-0 slave state
    int          clr_req = 0;
    int          clr_seen = 0;
    logic [31:0] s_next = '0;
    logic [31:0] s_bits = '0;
    int          s_idx = 0;
    int          m_cs, m_rise, m_edges, m_rxv, m_csrise, m_first, m_lastrise;
    int          m_hi_run, m_hi_min, m_hi_max, m_since, m_per_max;
    logic [31:0] m_mosi, m_dc;
    logic [7:0]  m_rx;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;

    // dut1 slave / monitor state
    logic [7:0]  s1_word = 8'hA5;
    int          s1_idx = 0;
    logic [7:0]  m1_mosi = '0;
    logic [7:0]  rx1 = '0;
    int          rxv1 = 0;
    logic        p1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        if0.i_miso = 1'b0;
        m_cs = 0; m_rise = 0; m_edges = 0; m_rxv = 0; m_csrise = 0; m_first = 0; m_lastrise = 0;
        m_hi_run = 0; m_hi_min = 1000; m_hi_max = 0; m_since = 0; m_per_max = 0;
        m_mosi = '0; m_dc = '0; m_rx = '0;
        forever begin
            @(negedge clk);
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                m_cs = 0; m_rise = 0; m_edges = 0; m_rxv = 0; m_csrise = 0; m_first = 0; m_lastrise = 0;
                m_hi_run = 0; m_hi_min = 1000; m_hi_max = 0; m_since = 0; m_per_max = 0;
                m_mosi = '0; m_dc = '0; m_rx = '0;
                s_bits = s_next; s_idx = 0;
            end
            if (!if0.o_cs) begin
                m_cs++;
                m_since++;
            end
            if (if0.o_sck && !prev_sck) begin
                m_rise++;
                m_edges++;
                if (m_rise == 1) m_first = m_cs;
                else if (m_since > m_per_max) m_per_max = m_since;
                m_since = 0;
                m_lastrise = m_cs;
                m_mosi = {m_mosi[30:0], if0.o_mosi};
                m_dc = {m_dc[30:0], if0.o_dc};
            end
            if (!if0.o_sck && prev_sck) begin
                m_edges++;
                if (m_hi_run < m_hi_min) m_hi_min = m_hi_run;
                if (m_hi_run > m_hi_max) m_hi_max = m_hi_run;
                m_hi_run = 0;
                s_idx++;
            end
            if (if0.o_sck) m_hi_run++;
            if (if0.o_rx_valid) begin
                m_rxv++;
                m_rx = if0.o_rx_data;
            end
            if (if0.o_cs && !prev_cs) m_csrise++;
            prev_sck = if0.o_sck;
            prev_cs = if0.o_cs;
            if0.i_miso = (s_idx < 32) ? s_bits[31 - s_idx] : 1'b0;
        end
    end

    initial begin
        if1.i_miso = s1_word[0];
        forever begin
            @(negedge clk);
            if (if1.o_sck && !p1) m1_mosi = {if1.o_mosi, m1_mosi[7:1]};
            if (!if1.o_sck && p1 && s1_idx < 7) s1_idx++;
            if (if1.o_rx_valid) begin
                rxv1++;
                rx1 = if1.o_rx_data;
            end
            p1 = if1.o_sck;
            if1.i_miso = s1_word[s1_idx];
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send0(input logic [7:0] d, input logic dc, input logic last,
                         input logic [3:0] div, input bit clr);
        int n;
        if0.i_data  = d;
        if0.i_dc    = dc;
        if0.i_last  = last;
        if0.i_div   = div;
        if0.i_valid = 1'b1;
        n = 0;
        while (!if0.o_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 400), 32'd1);
        if (clr) clr_req++;
        @(posedge clk);
        @(negedge clk);
        if0.i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (if0.o_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 1000), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sck"},  32'(if0.o_sck), 32'd0);
        check({tag, "_mosi"}, 32'(if0.o_mosi), 32'd1);
        check({tag, "_cs"},   32'(if0.o_cs), 32'd1);
        check({tag, "_dc"},   32'(if0.o_dc), 32'd1);
        check({tag, "_rx"},   32'(if0.o_rx_data), 32'd0);
        check({tag, "_rxv"},  32'(if0.o_rx_valid), 32'd0);
        check({tag, "_busy"}, 32'(if0.o_busy), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        vecs[0] = '{8'h2A, 1'b0, 4'd0, 8'h00, 8'h2A, 8'h00, 8'h00, 18, 2, 16, 1};
        vecs[1] = '{8'hC3, 1'b1, 4'd1, 8'h3C, 8'hC3, 8'h3C, 8'hFF, 34, 3, 31, 2};
        vecs[2] = '{8'h81, 1'b1, 4'd3, 8'hA5, 8'h81, 8'hA5, 8'hFF, 66, 5, 61, 4};
        vecs[3] = '{8'hFF, 1'b0, 4'd2, 8'h5A, 8'hFF, 8'h5A, 8'h00, 50, 4, 46, 3};

        if0.i_valid = 1'b0; if0.i_data = '0; if0.i_dc = 1'b0; if0.i_last = 1'b0; if0.i_div = '0;
        if1.i_valid = 1'b0; if1.i_data = '0; if1.i_dc = 1'b0; if1.i_last = 1'b0; if1.i_div = '0;

        #3 rst = 1'b0;
        #5 check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            s_next = {vecs[i].miso, 24'h0};
            send0(vecs[i].data, vecs[i].dc, 1'b1, vecs[i].div, 1'b1);
            wait_idle($sformatf("v%0d_done", i));
            check($sformatf("v%0d_mosi", i),   32'(m_mosi[7:0]), 32'(vecs[i].exp_mosi));
            check($sformatf("v%0d_rises", i),  m_rise, 8);
            check($sformatf("v%0d_cs_low", i), m_cs, vecs[i].exp_cs);
            check($sformatf("v%0d_first", i),  m_first, vecs[i].exp_first);
            check($sformatf("v%0d_lastr", i),  m_lastrise, vecs[i].exp_last);
            check($sformatf("v%0d_hi_min", i), m_hi_min, vecs[i].exp_hi);
            check($sformatf("v%0d_hi_max", i), m_hi_max, vecs[i].exp_hi);
            check($sformatf("v%0d_dc", i),     32'(m_dc[7:0]), 32'(vecs[i].exp_dc));
            check($sformatf("v%0d_rxv", i),    m_rxv, 1);
            check($sformatf("v%0d_rx", i),     32'(m_rx), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d_csrise", i), m_csrise, 1);
            check($sformatf("v%0d_idle_mosi", i), 32'(if0.o_mosi), 32'd1);
            check($sformatf("v%0d_idle_dc", i),   32'(if0.o_dc), 32'(vecs[i].dc));
        end

        // contiguous three-word burst
        s_next = 32'hDEADBE00;
        send0(8'h2C, 1'b0, 1'b0, 4'd0, 1'b1);
        send0(8'hF8, 1'b1, 1'b0, 4'd0, 1'b0);
        send0(8'h00, 1'b1, 1'b1, 4'd0, 1'b0);
        wait_idle("burst_done");
        check("burst_rises",  m_rise, 24);
        check("burst_mosi",   m_mosi[23:0], 24'h2CF800);
        check("burst_dc",     m_dc[23:0], 24'h00FFFF);
        check("burst_period", m_per_max, 2);
        check("burst_cs_low", m_cs, 50);
        check("burst_csrise", m_csrise, 1);
        check("burst_rxv",    m_rxv, 3);
        check("burst_rx",     32'(m_rx), 32'hBE);

        // stall between words
        s_next = 32'h12340000;
        send0(8'h3A, 1'b0, 1'b0, 4'd0, 1'b1);
        n = 0;
        while (!if0.o_rx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_reach_gap", 32'(n < 100), 32'd1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (if0.o_cs !== 1'b0 || if0.o_sck !== 1'b0 || if0.o_ready !== 1'b1 ||
                if0.o_busy !== 1'b1 || if0.o_mosi !== 1'b0) bad++;
            @(negedge clk);
        end
        check("stall_gap_pins", bad, 0);
        send0(8'h55, 1'b1, 1'b1, 4'd0, 1'b0);
        wait_idle("stall_done");
        check("stall_rises",  m_rise, 16);
        check("stall_mosi",   m_mosi[15:0], 16'h3A55);
        check("stall_dc",     m_dc[15:0], 16'h00FF);
        check("stall_period", m_per_max, 13);
        check("stall_cs_low", m_cs, 45);
        check("stall_csrise", m_csrise, 1);
        check("stall_rxv",    m_rxv, 2);
        check("stall_rx",     32'(m_rx), 32'h34);

        // divider change mid-burst is ignored, applies to the next burst
        s_next = 32'h0;
        send0(8'h96, 1'b0, 1'b0, 4'd1, 1'b1);
        send0(8'h69, 1'b1, 1'b1, 4'd5, 1'b0);
        wait_idle("div_a_done");
        check("div_a_hi_min", m_hi_min, 2);
        check("div_a_hi_max", m_hi_max, 2);
        check("div_a_rises",  m_rise, 16);
        check("div_a_cs_low", m_cs, 66);
        send0(8'h0F, 1'b1, 1'b1, 4'd5, 1'b1);
        wait_idle("div_b_done");
        check("div_b_hi_min", m_hi_min, 6);
        check("div_b_hi_max", m_hi_max, 6);
        check("div_b_first",  m_first, 7);
        check("div_b_cs_low", m_cs, 98);
        check("div_b_mosi",   32'(m_mosi[7:0]), 32'h0F);

        // reset after the third SCK edge
        s_next = 32'hFF000000;
        send0(8'hA5, 1'b1, 1'b1, 4'd1, 1'b1);
        n = 0;
        while (m_edges < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_edge3", 32'(n < 100), 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_no_rxv", m_rxv, 0);
        check("midrst_idle",   32'(if0.o_busy), 32'd0);
        check("midrst_cs",     32'(if0.o_cs), 32'd1);

        // LSB-first instance readback
        if1.i_data  = 8'h2A;
        if1.i_dc    = 1'b1;
        if1.i_last  = 1'b1;
        if1.i_div   = 4'd3;
        if1.i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if1.i_valid = 1'b0;
        n = 0;
        while (if1.o_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("lsb_done", 32'(n < 500), 32'd1);
        @(negedge clk);
        check("lsb_rx",   32'(rx1), 32'hA5);
        check("lsb_rxv",  rxv1, 1);
        check("lsb_mosi", 32'(m1_mosi), 32'h2A);
        check("lsb_cs",   32'(if1.o_cs), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
